// File: rtl/mem_access_unit_pkg.sv
// +------------------------------------------------------------------+
// | scoreboard_pkg : opcodes, address width and FSM state encoding    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package scoreboard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// +------------------------------------------------------------------+
// | mem_access_unit_if : ALU-side request and write-back bus          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface mem_access_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] IR;
  logic [31:0] alu_result;
  logic [9:0]  mem_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        st_done;

  modport master (
    output in_valid, IR, alu_result, mem_dest, wb_ready,
    input  in_ready, wb_valid, wb_reg, wb_data, st_done
  );

  modport slave (
    input  in_valid, IR, alu_result, mem_dest, wb_ready,
    output in_ready, wb_valid, wb_reg, wb_data, st_done
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_data_ram.sv
// +------------------------------------------------------------------+
// | data_ram : single-port word RAM, synchronous write and read       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module data_ram
  import scoreboard_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  wire logic              clock,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [31:0]       wdata,
  output logic      [31:0]       rdata
);

  logic [31:0] r_mem [MEM_DEPTH];

  // Read-during-write returns the old word; the FSM never relies on it.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +------------------------------------------------------------------+
// | mem_access_unit : lw/sw execution with fixed-latency data memory  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import scoreboard_pkg::*;
#(
  parameter int MEM_LAT   = 2,
  parameter int MEM_DEPTH = 1024
) (
  input wire logic          clock,
  input wire logic          reset,
  mem_access_unit_if.slave  bus
);

  localparam int CNT_W = 4;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_store;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [4:0]        r_dest;
  logic              r_wb_valid;
  logic [4:0]        r_wb_reg;
  logic [31:0]       r_wb_data;
  logic              r_st_done;

  logic [5:0]        w_op;
  logic              w_is_lw;
  logic              w_is_sw;
  logic              w_accept;
  logic              w_done;
  logic [ADDR_W-1:0] w_in_addr;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_op      = bus.IR[31:26];
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_done    = (r_state == ACCESS) && (r_cnt == '0);
  assign w_in_addr = w_is_sw ? bus.mem_dest : bus.alu_result[ADDR_W-1:0];
  assign w_unused  = ^bus.IR[25:0];

  // The RAM sees the incoming address in IDLE so a MEM_LAT=1 load has its
  // word registered by the completion edge.
  assign w_ram_addr = (r_state == IDLE) ? w_in_addr : r_addr;

  data_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clock (clock),
    .we    (w_done && r_is_store),
    .addr  (w_ram_addr),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dest     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
      r_st_done  <= 1'b0;
    end else begin
      r_st_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && (w_is_lw || w_is_sw)) begin
            r_is_store <= w_is_sw;
            r_addr     <= w_in_addr;
            r_wdata    <= bus.alu_result;
            r_dest     <= bus.mem_dest[4:0];
            r_cnt      <= CNT_W'(MEM_LAT - 1);
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            if (r_is_store) begin
              r_st_done <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_wb_data  <= w_rdata;
              r_wb_reg   <= r_dest;
              r_wb_valid <= 1'b1;
              r_state    <= RESP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_reg   = r_wb_reg;
  assign bus.wb_data  = r_wb_data;
  assign bus.st_done  = r_st_done;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles, legal range 1..15.
REQ-002 Parameter MEM_DEPTH, default 1024, data memory depth in 32-bit words, indexed by 10 bits.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request from the ALU stage is present.
REQ-006 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 IR  input  32  instruction word of the request; the opcode is IR[31:26].
REQ-008 alu_result  input  32  ALU output: the load address for lw, the store data for sw.
REQ-009 mem_dest  input  10  ALU side output: the destination register in [4:0] for lw, the store word address for sw.
REQ-010 wb_valid  output  1  load result available for register write-back.
REQ-011 wb_ready  input  1  scoreboard accepts the write-back.
REQ-012 wb_reg  output  5  destination register of the load.
REQ-013 wb_data  output  32  loaded word.
REQ-014 st_done  output  1  one-cycle pulse marking the completion of a store.

Function
REQ-015 A request is accepted on a rising edge where in_valid and in_ready are both high; IR, alu_result and mem_dest are captured at that edge.
REQ-016 Opcode 6'b100011 (lw): the word address is alu_result[9:0], the destination is mem_dest[4:0], and alu_result[31:10] is ignored, so addresses wrap modulo 1024.
REQ-017 Opcode 6'b101011 (sw): the word address is mem_dest[9:0] and the write data is alu_result.
REQ-018 Any other opcode is accepted and discarded with no memory access, no wb_valid and no st_done, and the unit stays in IDLE.
REQ-019 FSM states are IDLE, ACCESS and RESP; a latency counter runs in ACCESS.
REQ-020 IDLE -> ACCESS on acceptance of lw or sw, with the counter loaded to MEM_LAT-1.
REQ-021 In ACCESS the counter decrements each cycle; the access completes on the edge where the counter equals 0.
REQ-022 sw completion: memory is written at that edge, the FSM returns to IDLE, and st_done is high for exactly the following cycle.
REQ-023 lw completion: the memory word is captured into wb_data, wb_reg is set, and the FSM enters RESP with wb_valid high.
REQ-024 In RESP, wb_valid, wb_reg and wb_data hold stable until an edge with wb_ready high, after which the FSM goes to IDLE and wb_valid drops.
REQ-025 Load-to-writeback latency is exactly MEM_LAT cycles from the acceptance edge to the first cycle of wb_valid.
REQ-026 A load from an address sees every store that completed before that load was accepted (no stale read).
REQ-027 in_ready is low in ACCESS and RESP; there is no overlap of requests, so a new request can be accepted no sooner than the cycle after returning to IDLE.
REQ-028 wb_ready has no effect outside RESP.
REQ-029 Memory contents are not initialised and are not affected by reset.

Reset
REQ-030 When reset is asserted: FSM = IDLE, counter = 0, wb_valid = 0, wb_reg = 0, wb_data = 0, st_done = 0; in_ready is high once reset is released.
REQ-031 Reset during ACCESS aborts the request; a store whose completion edge has not occurred SHALL NOT modify memory.
REQ-032 Reset during RESP discards the pending write-back.

Structure
REQ-033 Package scoreboard_pkg holds the opcode constants OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011 and OP_SW = 6'b101011, the ADDR_W = 10 constant, and the FSM state enum.
REQ-034 One sub-module, data_ram: single port, MEM_DEPTH x 32, synchronous write, synchronous read, no reset.

Verification
REQ-035 sw with alu_result = 0xDEADBEEF and mem_dest = 10'd5, then lw with alu_result = 5 and mem_dest = 7 -> st_done pulses once; wb_valid is high exactly 2 cycles after lw acceptance with wb_reg = 7 and wb_data = 0xDEADBEEF.
REQ-036 lw with alu_result = 0x00000405 after a store of 0x12345678 to address 5 -> wb_data = 0x12345678 (address wrap).
REQ-037 lw with wb_ready held low for 3 cycles -> wb_valid, wb_reg and wb_data are stable for those 3 cycles, drop the cycle after wb_ready rises, and in_ready stays low throughout.
REQ-038 Reset asserted in ACCESS of sw 0xCAFEF00D to address 9 (MEM_LAT = 3), then lw from 9 -> wb_data equals the value stored at 9 before the aborted sw.
REQ-039 add IR (opcode 0, funct 6'b100000) with in_valid high for 4 cycles -> in_ready stays high, and there is no wb_valid and no st_done.
REQ-040 Back-to-back sw/lw pairs at addresses 0 and 1023 with MEM_LAT = 1 -> correct data, and no request is accepted while in_ready is low.
